// File: rtl/apb_uart_arbiter_pkg.sv
// Shared definitions for the APB UART arbiter: slave address map, FSM encoding
// and a modulo-increment helper for the round-robin pointer.
package apb_uart_arbiter_pkg;

    // UART slave register map (2-bit PADDR)
    localparam logic [1:0] APB_ADDR_WRITE = 2'd0;
    localparam logic [1:0] APB_ADDR_READ  = 2'd1;

    // APB master phase; encodings are shared with other APB blocks
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // (v + 1) mod n, without a divider
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/apb_uart_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    // scan N_REQ positions starting at ptr; the first hit wins
    always_comb begin
        int j;
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any_req && req[j]) begin
                any_req  = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/apb_uart_arbiter.sv
// Shares one APB UART slave among N_REQ requesters. Round-robin grant, one
// full SETUP/ACCESS transfer per grant, optional PREADY timeout.
module apb_uart_arbiter
    import apb_uart_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int BUS_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_write,
    input  logic [2*N_REQ-1:0]         req_addr,
    input  logic [BUS_WIDTH*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]           req_done,
    output logic [N_REQ-1:0]           req_err,
    output logic [BUS_WIDTH-1:0]       rsp_rdata,
    output logic [IDX_W-1:0]           grant_id,
    output logic [1:0]                 M_PADDR,
    output logic                       M_PWRITE,
    output logic                       M_PSELx,
    output logic                       M_PENABLE,
    output logic [BUS_WIDTH-1:0]       M_PWDATA,
    input  logic [BUS_WIDTH-1:0]       M_PRDATA,
    input  logic                       M_PREADY
);

    // counter needs at least one bit even when the timeout is disabled
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_state_e           state, state_next;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_W-1:0]     cnt;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic [N_REQ-1:0]     arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 pready_ok;
    logic                 timeout_hit;
    logic                 xfer_end;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any_req (arb_any)
    );

    // a floating or unknown PREADY must never complete a transfer
    assign pready_ok   = (M_PREADY === 1'b1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign xfer_end    = (state == ST_ACCESS) && (pready_ok || timeout_hit);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // next state and APB strobes / completion pulses; reset suppresses a
    // completion that would otherwise fire in the cycle reset is asserted
    always_comb begin
        state_next = state;
        M_PSELx    = 1'b0;
        M_PENABLE  = 1'b0;
        req_done   = '0;
        req_err    = '0;
        rsp_rdata  = rdata_q;
        case (state)
            ST_IDLE:   if (arb_any) state_next = ST_SETUP;
            ST_SETUP: begin
                M_PSELx    = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                M_PSELx   = 1'b1;
                M_PENABLE = 1'b1;
                if (xfer_end) begin
                    state_next = ST_IDLE;
                    if (!reset) begin
                        req_done[grant_id] = 1'b1;
                        req_err[grant_id]  = !pready_ok;
                        if (pready_ok && !M_PWRITE) rsp_rdata = M_PRDATA;
                    end
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // grant capture, wait counter, read-data hold and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            cnt      <= '0;
            rdata_q  <= '0;
            grant_id <= '0;
            M_PADDR  <= '0;
            M_PWRITE <= 1'b0;
            M_PWDATA <= '0;
        end else begin
            case (state)
                ST_IDLE: if (arb_any) begin
                    grant_id <= arb_idx;
                    M_PADDR  <= req_addr[int'(arb_idx)*2 +: 2];
                    M_PWRITE <= req_write[arb_idx];
                    M_PWDATA <= req_wdata[int'(arb_idx)*BUS_WIDTH +: BUS_WIDTH];
                end
                ST_SETUP: cnt <= '0;
                ST_ACCESS: begin
                    if (xfer_end) begin
                        ptr <= IDX_W'(wrap_inc(int'(grant_id), N_REQ));
                        if (pready_ok && !M_PWRITE) rdata_q <= M_PRDATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Directed bench for apb_uart_arbiter: a vector table of single transfers plus
// hand sequences for pointer advance, reset abort and full contention.
module tb_apb_uart_arbiter;
    import apb_uart_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_write = '0;
    logic [2*N-1:0]   req_addr  = '0;
    logic [W*N-1:0]   req_wdata = '0;
    logic [N-1:0]     req_done, req_err;
    logic [W-1:0]     rsp_rdata;
    logic [1:0]       grant_id;
    logic [1:0]       M_PADDR;
    logic             M_PWRITE, M_PSELx, M_PENABLE;
    logic [W-1:0]     M_PWDATA;
    logic [W-1:0]     M_PRDATA = '0;
    logic             pready_v = 1'b0;
    wire              M_PREADY;

    // slave only drives PREADY while selected
    assign M_PREADY = M_PSELx ? pready_v : 1'bz;

    always #5 clk = ~clk;

    apb_uart_arbiter #(.N_REQ(N), .BUS_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
        .req_err(req_err), .rsp_rdata(rsp_rdata), .grant_id(grant_id),
        .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
        .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
        .M_PREADY(M_PREADY)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // inputs change at the falling edge, outputs sampled 2ns later
    task automatic cyc();
        @(negedge clk);
    endtask

    typedef struct {
        int         idx;
        logic       wr;
        logic [1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] prdata;
        int         nwait;     // ACCESS cycles with PREADY low before it rises
        int         exp_k;     // ACCESS cycle (0-based) carrying req_done
        logic       exp_err;
        logic [W-1:0] exp_rd;  // rsp_rdata in and after the done cycle
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        logic done_seen;
        done_seen = 1'b0;
        cyc();
        req_valid = '0;
        req_valid[v.idx] = 1'b1;
        req_write[v.idx] = v.wr;
        req_addr[v.idx*2 +: 2] = v.addr;
        req_wdata[v.idx*W +: W] = v.wdata;
        pready_v = 1'b0;
        #2;
        chk("idle_psel", M_PSELx, 1'b0);
        // SETUP: scramble request fields to prove they are frozen
        cyc();
        req_addr[v.idx*2 +: 2]  = ~v.addr;
        req_wdata[v.idx*W +: W] = ~v.wdata;
        req_write[v.idx]        = ~v.wr;
        #2;
        chk("setup_psel", M_PSELx, 1'b1);
        chk("setup_penable", M_PENABLE, 1'b0);
        chk("setup_paddr", M_PADDR, v.addr);
        chk("setup_pwrite", M_PWRITE, v.wr);
        if (v.wr) chk("setup_pwdata", M_PWDATA, v.wdata);
        chk("setup_grant", grant_id, v.idx);
        chk("setup_done", req_done, 0);
        for (int k = 0; k < TO + 4 && !done_seen; k++) begin
            cyc();
            pready_v = (k == v.nwait) ? 1'b1 : ((k == 1) ? 1'bx : 1'b0);
            M_PRDATA = (k == v.nwait) ? v.prdata : 16'hFFFF;
            #2;
            if (M_PSELx !== 1'b1 || M_PENABLE !== 1'b1)
                chk("access_strobes", {M_PSELx, M_PENABLE}, 2'b11);
            if (req_done != 0) begin
                done_seen = 1'b1;
                chk("done_cycle", k, v.exp_k);
                chk("done_onehot", req_done, 1 << v.idx);
                chk("done_err", req_err, v.exp_err ? (1 << v.idx) : 0);
                chk("done_rdata", rsp_rdata, v.exp_rd);
                chk("access_pwdata_frozen", M_PWDATA, v.wr ? v.wdata : M_PWDATA);
                chk("access_paddr_frozen", M_PADDR, v.addr);
            end
        end
        chk("done_seen", done_seen, 1'b1);
        cyc();
        req_valid = '0;
        pready_v  = 1'b0;
        M_PRDATA  = 16'h0BAD;
        #2;
        chk("after_psel", M_PSELx, 1'b0);
        chk("after_penable", M_PENABLE, 1'b0);
        chk("after_done", req_done, 0);
        chk("after_rdata_held", rsp_rdata, v.exp_rd);
    endtask

    initial begin
        int   got;
        int   last_t;
        int   exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};

        //        idx wr  addr            wdata     prdata    nwait exp_k err exp_rd
        vecs[0] = '{0, 1'b1, APB_ADDR_WRITE, 16'h0041, 16'h0000, 0,   0,  1'b0, 16'h0000};
        vecs[1] = '{2, 1'b0, APB_ADDR_READ,  16'h0000, 16'h005A, 0,   0,  1'b0, 16'h005A};
        vecs[2] = '{1, 1'b1, APB_ADDR_WRITE, 16'h1234, 16'h7777, 10,  10, 1'b0, 16'h005A};
        vecs[3] = '{3, 1'b0, APB_ADDR_READ,  16'h0000, 16'hBEEF, 3,   3,  1'b0, 16'hBEEF};
        vecs[4] = '{0, 1'b0, APB_ADDR_READ,  16'h0000, 16'hDEAD, 999, 63, 1'b1, 16'hBEEF};
        vecs[5] = '{1, 1'b1, APB_ADDR_WRITE, 16'h00C3, 16'h0000, 0,   0,  1'b0, 16'hBEEF};

        // reset state
        cyc(); cyc();
        #2;
        chk("rst_psel", M_PSELx, 1'b0);
        chk("rst_penable", M_PENABLE, 1'b0);
        chk("rst_paddr", M_PADDR, 2'd0);
        chk("rst_pwrite", M_PWRITE, 1'b0);
        chk("rst_pwdata", M_PWDATA, 16'h0);
        chk("rst_done", req_done, 0);
        chk("rst_err", req_err, 0);
        chk("rst_rdata", rsp_rdata, 16'h0);
        chk("rst_grant", grant_id, 2'd0);
        cyc();
        reset = 1'b0;

        // table of single-requester transfers; vector 4 times out (ptr -> 1)
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // pointer advanced past the timed-out requester: 0 and 1 pending -> 1
        cyc();
        req_valid = 4'b0011; req_write = 4'b0011; pready_v = 1'b1;
        #2;
        cyc(); #2;
        chk("ptr_adv_grant", grant_id, 2'd1);
        cyc(); #2;
        chk("ptr_adv_done1", req_done, 4'b0010);
        cyc(); req_valid = 4'b0001; #2;
        chk("ptr_adv_idle", M_PSELx, 1'b0);
        cyc(); #2;
        chk("ptr_adv_grant0", grant_id, 2'd0);
        cyc(); #2;
        chk("ptr_adv_done0", req_done, 4'b0001);
        cyc(); req_valid = '0; pready_v = 1'b0;

        // req1 write completes, ptr -> 2
        run_vec(vecs[5]);

        // reset during ACCESS of req2 aborts without req_done
        cyc(); req_valid = 4'b0100; req_write = 4'b0000; pready_v = 1'b0;
        cyc();
        cyc(); #2;
        chk("abort_in_access", M_PENABLE, 1'b1);
        cyc(); reset = 1'b1; pready_v = 1'b1; #2;
        chk("abort_rst_done", req_done, 0);
        cyc(); reset = 1'b0; req_valid = 4'b1010; pready_v = 1'b0; #2;
        chk("abort_psel", M_PSELx, 1'b0);
        chk("abort_penable", M_PENABLE, 1'b0);
        chk("abort_done", req_done, 0);
        chk("abort_rdata_cleared", rsp_rdata, 16'h0);
        cyc(); #2;
        chk("abort_grant1", grant_id, 2'd1);
        cyc(); pready_v = 1'b1; #2;
        chk("abort_done1", req_done, 4'b0010);
        cyc(); req_valid = 4'b1000; #2;
        cyc(); #2;
        chk("abort_grant3", grant_id, 2'd3);
        cyc(); #2;
        chk("abort_done3", req_done, 4'b1000);
        cyc(); req_valid = '0; pready_v = 1'b0;

        // contention: fresh reset, everyone pending, zero-wait slave
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; req_valid = 4'b1111; pready_v = 1'b1;
        got = 0;
        last_t = -3;
        for (int t = 0; t < 40 && got < 6; t++) begin
            cyc(); #2;
            if (req_done != 0) begin
                int who;
                who = 0;
                for (int b = 0; b < N; b++) if (req_done[b]) who = b;
                chk("cont_onehot", $countones(req_done), 1);
                chk("cont_order", who, exp_order[got]);
                if (got > 0) chk("cont_spacing", t - last_t, 3);
                last_t = t;
                got++;
            end
        end
        chk("cont_count", got, 6);
        cyc(); req_valid = '0; pready_v = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
